imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that sits directly upstream of the multicycle MIPS core. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into instruction memory from address 0 and holds the core in reset until a complete, checksum-verified image is in place. On a framing or checksum error the core stays in reset and an error flag is raised.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at a rising edge.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  active-low reset to the MIPS core; low until the load succeeds.
- load_done  out  1  image loaded and verified; sticky until rst.
- load_err  out  1  load failed; sticky until rst.

## Operation
- Stream format, in order:
  - count high byte, then count low byte, giving a 16-bit word count N;
  - N words, each 4 bytes, MSB first;
  - one checksum byte.
- Checksum: XOR of every preceding byte, including the two count bytes. The checksum byte must equal this value.
- States and transitions:
  - CNT_HI: accepts a byte into N[15:8], then goes to CNT_LO.
  - CNT_LO: accepts a byte into N[7:0].
    - If N > 2^ADDR_W, goes to ERROR.
    - If N = 0, goes to CHECK.
    - Otherwise goes to DATA.
  - DATA: assembles bytes into a shift register with a byte counter of 0..3.
    - On the 4th byte, the word is registered to imem_wdata with imem_addr = word index, and imem_we pulses for one cycle.
    - The word index increments; after word N-1 the state goes to CHECK.
  - CHECK: accepts one byte. If it matches the running XOR, goes to DONE; otherwise goes to ERROR.
  - DONE: rx_ready=0, cpu_rst=1, load_done=1. Terminal.
  - ERROR: rx_ready=0, cpu_rst=0, load_err=1. Terminal; only rst exits.
- rx_ready is 1 in CNT_HI, CNT_LO, DATA and CHECK, including the cycle in which imem_we is pulsing. No stall is inserted.
- Index and word arithmetic:
  - The word index is ADDR_W+1 bits wide, so that N = 2^ADDR_W is accepted.
  - imem_addr carries the low ADDR_W bits.
  - The index never wraps within a legal load.
- Bytes offered while rx_ready=0 are ignored and not consumed.

## Timing
- Reset values (asynchronous, while rst=0):
  - State = CNT_HI; N, byte counter, word index and checksum all 0.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, load_done=0, load_err=0.
- rx_ready rises on the first clock edge after rst deasserts.
- Write latency: imem_we/imem_addr/imem_wdata are valid in the cycle after the edge that accepts the 4th byte of a word.
- Back-to-back words at one byte per cycle give one imem_we pulse every 4 cycles.
- Completion latency: cpu_rst and load_done, or load_err, go high one cycle after the edge that accepts the checksum byte. For the oversize case, the trigger is the count low byte.
- The last data word's imem_we pulse precedes or coincides with the CHECK-state byte acceptance. Memory is always complete before cpu_rst rises.
- Gaps (rx_valid=0) in any state hold all state; no timeout.
- Reset mid-load aborts immediately: outputs return to reset values, and partial memory contents are not erased. The next load restarts at CNT_HI and address 0.

## Test plan
- Nominal 2-word load: stream 00 02 12 34 56 78 9A BC DE F0 + chk 0x02 -> two imem_we pulses:
  - addr 0 = 0x12345678;
  - addr 1 = 0x9ABCDEF0;
  - cpu_rst=1 and load_done=1 one cycle after the checksum byte;
  - load_err=0.
- Zero-length image: 00 00 00 -> no imem_we; load_done=1, cpu_rst=1.
- Bad checksum: same stream as nominal but chk 0x03 -> both writes occur, load_err=1, cpu_rst stays 0, rx_ready=0 thereafter.
- Oversize count, ADDR_W=10: 04 01 -> load_err=1 after the 2nd byte, no writes. Count 04 00 with 1024 words and a correct checksum -> last write at addr 1023, load_done=1.
- Backpressure/gaps: nominal stream with random rx_valid idle cycles -> identical writes and final state. Bytes offered after DONE are not accepted.
- Reset mid-load: drop rst after 6 bytes of the nominal stream -> all outputs at reset values at once. The full nominal stream after release completes correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a byte stream into big-endian words, writes instruction memory from
// address 0 and releases the core from reset once the image checksum verifies.
module imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned IdxW     = ADDR_W + 1;
    localparam logic [16:0] MaxWords = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [IdxW-1:0]   widx_q, widx_d;
    logic [7:0]        chk_q, chk_d;
    logic [23:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic accept;
    logic last_word;

    assign accept    = rx_valid && ready_q;
    assign last_word = (17'(widx_q) + 17'd1) == {1'b0, n_q};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        widx_d     = widx_q;
        chk_d      = chk_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (accept) begin
            unique case (state_q)
                StCntHi: begin
                    n_d[15:8] = rx_data;
                    chk_d     = chk_q ^ rx_data;
                    state_d   = StCntLo;
                end
                StCntLo: begin
                    n_d[7:0] = rx_data;
                    chk_d    = chk_q ^ rx_data;
                    if ({1'b0, n_q[15:8], rx_data} > MaxWords) begin
                        state_d = StError;
                    end else if ({n_q[15:8], rx_data} == 16'd0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    chk_d      = chk_q ^ rx_data;
                    shift_d    = {shift_q[15:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_W-1:0];
                        wdata_d = {shift_q, rx_data};
                        widx_d  = widx_q + IdxW'(1);
                        if (last_word) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    state_d = (rx_data == chk_q) ? StDone : StError;
                end
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they land together with the state.
        ready_d = (state_d == StCntHi) || (state_d == StCntLo) ||
                  (state_d == StData)  || (state_d == StCheck);
        done_d  = (state_d == StDone);
        err_d   = (state_d == StError);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StCntHi;
            n_q        <= '0;
            byte_cnt_q <= '0;
            widx_q     <= '0;
            chk_q      <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            widx_q     <= widx_d;
            chk_q      <= chk_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = done_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vector table, hand-written timing/reset sequences and random
// images checked against a stream-level reference model.
module tb_imem_loader;

    localparam int unsigned AW  = 10;
    localparam int unsigned Cap = 1 << AW;

    typedef logic [7:0]    byte_q_t[$];
    typedef logic [AW-1:0] addr_q_t[$];
    typedef logic [31:0]   data_q_t[$];

    typedef struct {
        int          len;
        logic [95:0] b;
        logic        exp_done;
        logic        exp_err;
        int          exp_nwr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    addr_q_t wr_addr_q;
    data_q_t wr_data_q;
    int      wr_cyc_q[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_writes;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic do_reset;
        rx_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("reset outputs", 64'({rx_ready, imem_we, imem_addr, imem_wdata,
                                    cpu_rst, load_done, load_err}), 64'd0);
        clear_writes();
        rst = 1'b1;
        @(negedge clk);
        check("rx_ready after reset release", 64'(rx_ready), 64'd1);
    endtask

    // Offers each byte until accepted; returns the cycle stamp of every accepting edge.
    task automatic send(input byte_q_t b, input bit gaps, output int acc[$]);
        int wait_n;
        acc = {};
        foreach (b[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b[i];
            wait_n   = 0;
            while (!rx_ready) begin
                if (wait_n == 20) begin
                    check("handshake timeout", 64'(i), 64'(b.size()));
                    rx_valid = 1'b0;
                    return;
                end
                @(negedge clk);
                wait_n++;
            end
            @(posedge clk);
            #1;
            acc.push_back(cyc);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reference: interpret the stream by its format rules.
    task automatic model(input byte_q_t b, output addr_q_t ea, output data_q_t ed,
                         output logic done, output logic err);
        int n;
        int p;
        logic [7:0] x;
        ea   = {};
        ed   = {};
        done = 1'b0;
        err  = 1'b0;
        n    = {b[0], b[1]};
        if (n > Cap) begin
            err = 1'b1;
            return;
        end
        x = b[0] ^ b[1];
        for (int k = 0; k < n; k++) begin
            p = 2 + 4 * k;
            ea.push_back(AW'(k));
            ed.push_back({b[p], b[p+1], b[p+2], b[p+3]});
            x = x ^ b[p] ^ b[p+1] ^ b[p+2] ^ b[p+3];
        end
        if (b[2 + 4 * n] == x) done = 1'b1;
        else err = 1'b1;
    endtask

    task automatic compare_load(input string tag, input byte_q_t b);
        addr_q_t ea;
        data_q_t ed;
        logic    d;
        logic    e;
        int      m;
        model(b, ea, ed, d, e);
        check({tag, " load_done"}, 64'(load_done), 64'(d));
        check({tag, " load_err"}, 64'(load_err), 64'(e));
        check({tag, " cpu_rst"}, 64'(cpu_rst), 64'(d));
        check({tag, " rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, " write count"}, 64'(wr_addr_q.size()), 64'(ea.size()));
        m = (wr_addr_q.size() < ea.size()) ? wr_addr_q.size() : ea.size();
        for (int k = 0; k < m; k++) begin
            check({tag, " write addr"}, 64'(wr_addr_q[k]), 64'(ea[k]));
            check({tag, " write data"}, 64'(wr_data_q[k]), 64'(ed[k]));
        end
    endtask

    function automatic byte_q_t nominal(input logic [7:0] chk);
        byte_q_t q;
        q = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, chk};
        return q;
    endfunction

    vec_t    tbl[7];
    byte_q_t bytes;
    int      acc[$];

    initial begin
        tbl[0] = '{len: 11, b: 96'h0002_12345678_9ABCDEF0_02_00, exp_done: 1, exp_err: 0, exp_nwr: 2};
        tbl[1] = '{len: 3,  b: 96'h0,                            exp_done: 1, exp_err: 0, exp_nwr: 0};
        tbl[2] = '{len: 11, b: 96'h0002_12345678_9ABCDEF0_03_00, exp_done: 0, exp_err: 1, exp_nwr: 2};
        tbl[3] = '{len: 2,  b: 96'h0401_00000000_00000000_0000,  exp_done: 0, exp_err: 1, exp_nwr: 0};
        tbl[4] = '{len: 2,  b: 96'hFFFF_00000000_00000000_0000,  exp_done: 0, exp_err: 1, exp_nwr: 0};
        tbl[5] = '{len: 3,  b: 96'h000001_00000000_00000000_00,  exp_done: 0, exp_err: 1, exp_nwr: 0};
        tbl[6] = '{len: 7,  b: 96'h0001DEADBEEF23_0000000000,    exp_done: 1, exp_err: 0, exp_nwr: 1};

        do_reset();

        foreach (tbl[i]) begin
            do_reset();
            bytes = {};
            for (int j = 0; j < tbl[i].len; j++) bytes.push_back(tbl[i].b[95 - 8 * j -: 8]);
            send(bytes, 1'b0, acc);
            check($sformatf("tbl%0d load_done", i), 64'(load_done), 64'(tbl[i].exp_done));
            check($sformatf("tbl%0d load_err", i), 64'(load_err), 64'(tbl[i].exp_err));
            check($sformatf("tbl%0d cpu_rst", i), 64'(cpu_rst), 64'(tbl[i].exp_done));
            check($sformatf("tbl%0d writes", i), 64'(wr_addr_q.size()), 64'(tbl[i].exp_nwr));
            compare_load($sformatf("tbl%0d", i), bytes);
        end

        // Nominal image, back-to-back bytes: exact data, write latency and spacing.
        do_reset();
        send(nominal(8'h02), 1'b0, acc);
        check("nominal write count", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2 && acc.size() == 11) begin
            check("nominal addr0", 64'(wr_addr_q[0]), 64'd0);
            check("nominal data0", 64'(wr_data_q[0]), 64'h12345678);
            check("nominal addr1", 64'(wr_addr_q[1]), 64'd1);
            check("nominal data1", 64'(wr_data_q[1]), 64'h9ABCDEF0);
            check("write0 latency", 64'(wr_cyc_q[0]), 64'(acc[5]));
            check("write1 latency", 64'(wr_cyc_q[1]), 64'(acc[9]));
            check("write spacing", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd4);
        end
        check("nominal load_done", 64'(load_done), 64'd1);
        check("nominal cpu_rst", 64'(cpu_rst), 64'd1);
        check("nominal load_err", 64'(load_err), 64'd0);

        // Bytes offered after completion must not be taken.
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            check("rx_ready after done", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        check("no write after done", 64'(wr_data_q.size()), 64'd2);
        check("done sticky", 64'(load_done), 64'd1);

        // Same image with idle gaps.
        do_reset();
        send(nominal(8'h02), 1'b1, acc);
        compare_load("gapped nominal", nominal(8'h02));

        // Full-capacity image: count 0x0400.
        do_reset();
        bytes = {8'h04, 8'h00};
        for (int k = 0; k < 4 * Cap; k++) bytes.push_back(8'($urandom));
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (bytes[k]) x = x ^ bytes[k];
            bytes.push_back(x);
        end
        send(bytes, 1'b0, acc);
        compare_load("full capacity", bytes);
        if (wr_addr_q.size() > 0) check("last addr", 64'(wr_addr_q[wr_addr_q.size() - 1]), 64'd1023);

        // Reset while the first word's write strobe is high.
        do_reset();
        bytes = nominal(8'h02);
        bytes = bytes[0:5];
        send(bytes, 1'b0, acc);
        check("write before abort", 64'(imem_we), 64'd1);
        rst = 1'b0;
        #1;
        check("outputs at abort", 64'({rx_ready, imem_we, imem_addr, imem_wdata,
                                        cpu_rst, load_done, load_err}), 64'd0);
        @(negedge clk);
        clear_writes();
        rst = 1'b1;
        @(negedge clk);
        send(nominal(8'h02), 1'b0, acc);
        compare_load("after abort", nominal(8'h02));

        // Random images: small sizes, occasional oversize count or corrupted checksum.
        for (int t = 0; t < 25; t++) begin
            int n;
            logic [7:0] x;
            do_reset();
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(Cap + 1, 65535))
                                            : int'($urandom_range(0, 6));
            bytes = {8'(n >> 8), 8'(n)};
            if (n <= Cap) begin
                for (int k = 0; k < 4 * n; k++) bytes.push_back(8'($urandom));
                x = 8'h00;
                foreach (bytes[k]) x = x ^ bytes[k];
                if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
                bytes.push_back(x);
            end
            send(bytes, 1'b1, acc);
            compare_load($sformatf("random%0d", t), bytes);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
